// File: rtl/seq_divider_32_if.sv
// Operand/result handshake bundle for the 32/16 sequential divider.
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high; a producer holds valid and its data stable until that edge,
// and ready may depend on state only, never combinationally on valid.
interface seq_divider_32_if #(
   parameter int DW = 32,
   parameter int VW = 16
);
   logic          start_valid;
   logic          start_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;
   logic          busy;

   // Requester side: issues operands and consumes results.
   modport master (
      output start_valid, dividend, divisor, out_ready,
      input  start_ready, out_valid, quotient, remainder, div_by_zero, busy
   );

   // Divider side.
   modport slave (
      input  start_valid, dividend, divisor, out_ready,
      output start_ready, out_valid, quotient, remainder, div_by_zero, busy
   );
endinterface

// File: rtl/seq_divider_32.sv
// Unsigned 32/16 restoring divider, one quotient bit per cycle, MSB first.
// Divide-by-zero short-cuts straight to the result state with all-ones
// quotient and the low dividend half as remainder.
module seq_divider_32 #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic             clk,
   input  logic             rst,
   seq_divider_32_if.slave  bus,
   output logic [1:0]       dbg_state_o
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
   localparam logic [VW:0]   ONE_W     = (VW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dvd_q;    // dividend bits still to consume; quotient bits shift in at the bottom
   logic [VW-1:0] dvs_q;
   logic [VW:0]   prem_q;   // partial remainder
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] quo_q;
   logic [VW-1:0] rem_q;
   logic          dbz_q;

   logic          accept;
   logic [VW:0]   shifted;
   logic [VW:0]   trial;
   logic          qbit;
   logic [VW:0]   prem_nxt;

   assign accept = bus.start_valid && (state_q == IDLE);

   // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
   always_comb begin
      shifted  = {prem_q[VW-1:0], dvd_q[DW-1]};
      trial    = shifted + ~{1'b0, dvs_q} + ONE_W;
      qbit     = ~trial[VW];
      prem_nxt = qbit ? trial : shifted;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      state_d         = state_q;
      bus.start_ready = 1'b0;
      bus.out_valid   = 1'b0;
      bus.busy        = 1'b1;
      case (state_q)
         IDLE: begin
            bus.start_ready = 1'b1;
            bus.busy        = 1'b0;
            if (accept) state_d = (bus.divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            if (cnt_q == LAST_STEP) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         prem_q <= '0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dvd_q  <= bus.dividend;
                  dvs_q  <= bus.divisor;
                  prem_q <= '0;
                  cnt_q  <= '0;
                  if (bus.divisor == '0) begin
                     quo_q <= '1;
                     rem_q <= bus.dividend[VW-1:0];
                     dbz_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               prem_q <= prem_nxt;
               dvd_q  <= {dvd_q[DW-2:0], qbit};
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) begin
                  quo_q <= {dvd_q[DW-2:0], qbit};
                  rem_q <= prem_nxt[VW-1:0];
                  dbz_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Randomised and directed bench for seq_divider_32 with a reference model
// built on plain integer division.
module tb_seq_divider_32;

   localparam int DW = 32;
   localparam int VW = 16;
   localparam int W  = DW + VW + 1;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   seq_divider_32_if #(.DW(DW), .VW(VW)) bus ();

   seq_divider_32 #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           due_q[$];
   bit           valid_seen = 1'b0;
   int           checks = 0;
   int           failures = 0;
   int           acc_cyc = 0;
   int           prev_acc = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: plain integer division, with the defined divide-by-zero result.
   function automatic logic [W-1:0] ref_pack(input logic [DW-1:0] a, input logic [VW-1:0] b);
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      if (b == '0) return {32'hFFFF_FFFF, a[VW-1:0], 1'b1};
      q = a / {16'd0, b};
      r = a % {16'd0, b};
      return {q, r[VW-1:0], 1'b0};
   endfunction

   // Monitor: compares outputs on every valid cycle, pops when valid drops.
   always @(negedge clk) begin
      if (!rst) begin
         check("ready_vs_busy", bus.start_ready, !bus.busy);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", bus.out_valid, 1'b0);
            end else begin
               if (!valid_seen) begin
                  check("latency", cyc, due_q[0]);
                  valid_seen = 1'b1;
               end
               check("quotient",    bus.quotient,    exp_q[0][W-1 -: DW]);
               check("remainder",   bus.remainder,   exp_q[0][VW:1]);
               check("div_by_zero", bus.div_by_zero, exp_q[0][0]);
            end
         end else if (valid_seen) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            valid_seen = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns just after the accepting rising edge.
   task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
      int budget = 0;
      while (!bus.start_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("issue_ready", bus.start_ready, 1'b1);
      bus.start_valid = 1'b1;
      bus.dividend    = a;
      bus.divisor     = b;
      @(posedge clk);
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      exp_q.push_back(ref_pack(a, b));
      due_q.push_back(cyc + ((b == '0) ? 1 : 33));
      #1;
      bus.start_valid = 1'b0;
   endtask

   // Issue, disturb the operand inputs while busy, then consume the result
   // (optionally with random back-pressure). Returns at a falling edge in IDLE.
   task automatic run_one(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit bp);
      int budget = 0;
      bit done = 1'b0;
      issue(a, b);
      while (!done && budget < 200) begin
         @(negedge clk);
         budget++;
         if (bus.out_valid) begin
            bus.start_valid = 1'b0;
            bus.out_ready   = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            done            = bus.out_ready;
         end else begin
            bus.start_valid = 1'b1;
            bus.dividend    = $urandom;
            bus.divisor     = 16'($urandom);
         end
      end
      check("result_timeout", done, 1'b1);
      bus.start_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      int            budget;

      rst             = 1'b1;
      bus.start_valid = 1'b1;          // must not be taken while in reset
      bus.dividend    = 32'd77;
      bus.divisor     = 16'd0;
      bus.out_ready   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", bus.out_valid,   1'b0);
      check("rst_quotient",  bus.quotient,    32'd0);
      check("rst_remainder", bus.remainder,   16'd0);
      check("rst_dbz",       bus.div_by_zero, 1'b0);
      check("rst_busy",      bus.busy,        1'b0);
      rst             = 1'b0;
      bus.start_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", bus.start_ready, 1'b1);
      check("post_rst_valid", bus.out_valid,   1'b0);

      // Directed cases, issued back to back.
      run_one(32'd100, 16'd7, 1'b0);
      run_one(32'h1234_5678, 16'hFFFF, 1'b0);
      check("issue_interval", acc_cyc - prev_acc, 34);
      run_one(32'hFFFF_FFFF, 16'd1, 1'b0);
      run_one(32'd3, 16'h8000, 1'b0);
      run_one(32'd5, 16'd0, 1'b0);
      run_one(32'd0, 16'd9, 1'b0);

      // Result held under back-pressure while the inputs churn.
      bus.out_ready = 1'b0;
      issue(32'd1000, 16'd33);
      budget = 0;
      @(negedge clk);
      while (!bus.out_valid && budget < 100) begin
         bus.start_valid = 1'b1;
         bus.dividend    = $urandom;
         bus.divisor     = 16'($urandom);
         @(negedge clk);
         budget++;
      end
      check("hold_reach_valid", bus.out_valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         bus.start_valid = 1'b1;
         bus.dividend    = $urandom;
         bus.divisor     = 16'($urandom_range(0, 3));
         check("hold_ready_low", bus.start_ready, 1'b0);
         check("hold_valid_high", bus.out_valid, 1'b1);
         @(negedge clk);
      end
      bus.start_valid = 1'b0;
      bus.out_ready   = 1'b1;
      @(negedge clk);
      check("release_ready", bus.start_ready, 1'b1);
      check("release_valid", bus.out_valid,   1'b0);

      // Reset in the middle of an operation aborts it.
      issue(32'd100, 16'd7);
      repeat (16) @(negedge clk);
      rst             = 1'b1;
      bus.start_valid = 1'b1;
      bus.dividend    = 32'd42;
      bus.divisor     = 16'd0;
      exp_q.delete();
      due_q.delete();
      valid_seen = 1'b0;
      @(negedge clk);
      check("abort_valid",     bus.out_valid,   1'b0);
      check("abort_quotient",  bus.quotient,    32'd0);
      check("abort_remainder", bus.remainder,   16'd0);
      check("abort_dbz",       bus.div_by_zero, 1'b0);
      rst             = 1'b0;
      bus.start_valid = 1'b0;
      @(negedge clk);
      check("abort_ready", bus.start_ready, 1'b1);
      repeat (40) @(negedge clk);
      check("abort_quiet", bus.out_valid, 1'b0);
      run_one(32'd9, 16'd4, 1'b0);

      // Randomised operands with mixed divisor classes and back-pressure.
      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
         case ($urandom_range(0, 5))
            0:       b = 16'd0;
            1:       b = 16'd1;
            2:       b = 16'hFFFF;
            3:       b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         run_one(a, b, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider_32.md
SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 Parameter DW, 32, dividend and quotient width; it SHALL be fixed at 32 for this release.
REQ-002 Parameter VW, 16, divisor and remainder width; it SHALL be fixed at 16 for this release.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-005 start_valid  input  1  operands present this cycle.
REQ-006 start_ready  output  1  block accepts operands; asserted only in IDLE.
REQ-007 dividend  input  DW  unsigned dividend.
REQ-008 divisor  input  VW  unsigned divisor.
REQ-009 out_valid  output  1  result registers valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DW  unsigned quotient.
REQ-012 remainder  output  VW  unsigned remainder.
REQ-013 div_by_zero  output  1  current result came from divisor == 0.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; start_ready SHALL equal (state==IDLE), and busy SHALL equal (state!=IDLE).
REQ-016 Acceptance SHALL occur on any edge where start_valid & start_ready; dividend and divisor SHALL be latched into internal registers at that edge.
REQ-017 If the latched divisor != 0: next state RUN, partial remainder cleared to 17 bits of 0, iteration counter = 0.
REQ-018 If the latched divisor == 0: next state DONE; quotient = 32'hFFFFFFFF; remainder = dividend[15:0]; div_by_zero = 1; out_valid visible the cycle after acceptance.
REQ-019 Each RUN cycle SHALL perform one restoring step:
- shift the partial remainder left one bit, taking the next dividend bit, MSB first;
- compute trial = shifted + ~{1'b0,divisor} + 1, a 17-bit two's-complement add with carry-in 1;
- if the trial is non-negative, keep it and set the quotient bit to 1; otherwise restore the shifted value and set the quotient bit to 0.
REQ-020 RUN SHALL last exactly 32 cycles (counter 0..31); at counter==31 the next state SHALL be DONE and out_valid SHALL rise.
REQ-021 Latency SHALL be 33 cycles for non-zero divisors: with acceptance at edge t0, out_valid is high in cycle t0+33 (cycle 33 counted from acceptance).
REQ-022 In DONE: out_valid=1; quotient, remainder and div_by_zero SHALL hold stable until the edge where out_valid & out_ready.
REQ-023 At the out_valid & out_ready edge the next state SHALL be IDLE, with no combinational bypass; start_ready rises in the following cycle.
REQ-024 start_valid, dividend and divisor SHALL be ignored while busy; changes to them SHALL NOT affect the in-flight result.
REQ-025 In IDLE: out_valid=0, and quotient, remainder and div_by_zero SHALL retain their last values.
REQ-026 The remainder SHALL always be < divisor for divisor != 0, and dividend SHALL equal quotient*divisor + remainder.
REQ-027 A single back-to-back operation SHALL NOT overlap a pending result; the minimum issue interval is 34 cycles with out_ready held at 1.

Reset
REQ-028 While rst=1: state=IDLE, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0, partial remainder=0, latched operands=0.
REQ-029 start_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted operation.
REQ-031 start_valid coincident with rst=1 SHALL NOT be accepted.

Verification
REQ-032 dividend=100, divisor=7 -> out_valid at cycle 33; quotient=14, remainder=2, div_by_zero=0.
REQ-033 dividend=32'h12345678, divisor=16'hFFFF -> quotient=32'h00001234, remainder=16'h68AC.
REQ-034 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0; then dividend=3, divisor=16'h8000 -> quotient=0, remainder=3.
REQ-035 dividend=5, divisor=0 -> out_valid in cycle 1 after acceptance; quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1.
REQ-036 out_ready held 0 for 10 cycles after out_valid, with start_valid=1 and changing operands -> outputs stable, start_ready=0; after out_ready=1 -> IDLE and start_ready=1 on the next cycle.
REQ-037 Reset pulse at RUN cycle 16 of 100/7 -> out_valid stays 0, all outputs 0, start_ready=1 after release; a new 9/4 SHALL then give quotient=2, remainder=1.
